audio_capture_recorder: RTL
===========================

# audio_capture_recorder

Capture-side counterpart to the ROM playback path. Drains left/right samples from the audio CODEC read interface, selects one channel, converts 24-bit CODEC samples to 16-bit, optionally decimates, and writes them sequentially into a single-port RAM whose layout matches the playback ROM (16-bit words, address 0 upward). Sits beside the CODEC instance on CLOCK_50 and owns the CODEC `read` strobe.

## Interface
- `ADDR_W`, 16, RAM address width.
- `DEPTH`, 52612, number of words recorded before auto-stop; must be ≤ 2^ADDR_W.
- `DECIM`, 1, keep one of every DECIM accepted CODEC samples; DECIM ≥ 1.

- `clk`  in  1  system clock (CLOCK_50 domain); one clock only.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begin a recording from address 0.
- `stop`  in  1  one-cycle pulse; end the recording early.
- `channel_sel`  in  1  0 = readdata_left, 1 = readdata_right.
- `read_ready`  in  1  CODEC has a sample pair available.
- `readdata_left`, `readdata_right`  in  24 each  CODEC sample pair, valid while read_ready = 1.
- `read`  out  1  CODEC pop strobe.
- `mem_addr`  out  ADDR_W  RAM write address.
- `mem_wdata`  out  16  RAM write data.
- `mem_we`  out  1  RAM write enable, one cycle per word.
- `busy`  out  1  high in ARM/CAPTURE.
- `done`  out  1  high in DONE.
- `word_count`  out  ADDR_W  words written in the current/last recording.

## Operation
- States: IDLE, ARM, CAPTURE, DONE. Reset -> IDLE.
- IDLE: `start` -> ARM. `start` and `stop` in the same cycle: `stop` wins, stay IDLE.
- ARM (one cycle): clear address, word_count, decimation counter -> CAPTURE.
- CAPTURE: each accepted sample increments decimation counter (0..DECIM-1, wraps); sample stored only when counter = 0 at acceptance.
- CAPTURE -> DONE when the word at address DEPTH-1 is written, or on `stop`. A sample latched before `stop` still has its write completed; no new sample is stored after `stop`.
- DONE: outputs hold; `start` -> ARM (new recording overwrites from 0). `stop` in DONE/IDLE ignored. `start` in ARM/CAPTURE ignored.
- CODEC draining: `read` is generated in every state (not only CAPTURE) so the CODEC FIFO never overflows; samples outside CAPTURE are discarded.
- Conversion: `mem_wdata = sample[23:8]` (truncation) unless the macro below is defined.

## Timing
- Reset values: read 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, word_count 0.
- `read` registered: `read <= read_ready & ~read` — one-cycle pulse, never high two consecutive cycles.
- Sample accepted on the edge ending the cycle where read = 1; selected channel latched then.
- read_ready high at edge k -> read high cycle k+1 -> sample latched at edge k+2 -> mem_we high cycle k+2 with mem_addr = current address -> address and word_count increment at edge k+3.
- mem_we never high two consecutive cycles.
- DEPTH reached: DONE entered at the edge where the final mem_we cycle ends; word_count = DEPTH, mem_addr holds DEPTH-1.
- Address never wraps past DEPTH-1.
- `reset_n` low mid-recording: all state and outputs to reset values immediately (asynchronous); a pending write is abandoned.

## Configuration
- `AUDIO_REC_ROUND_SAT_EN` defined: mem_wdata = sample[23:8] + sample[7], saturated to 16'h7FFF when the addition overflows positive; negative values cannot overflow.
- Undefined: plain truncation sample[23:8]; no adder in the path.

## Test plan
- Reset then idle with read_ready held 1 -> read toggles 1,0,1,0…, mem_we stays 0, done 0.
- DEPTH=4, DECIM=1, start, feed left = 24'h123456, 24'h00FF00, 24'hFFFFFF, 24'h800000 -> writes 16'h1234,16'h00FF,16'hFFFF,16'h8000 at addr 0..3, done = 1, word_count = 4.
- DECIM=3, channel_sel=1, right samples 1..9 (value<<8) -> only samples 1,4,7 written at addr 0,1,2.
- stop pulsed one cycle after a sample is latched -> that word still written, no further mem_we, done = 1, word_count correct.
- start and stop same cycle in IDLE -> stays IDLE; start during CAPTURE -> no effect; start in DONE -> addr restarts at 0.
- With AUDIO_REC_ROUND_SAT_EN: 24'h7FFF80 -> 16'h7FFF (saturated), 24'h001280 -> 16'h0013; reset_n pulsed low mid-write -> mem_we drops immediately, all outputs reset.

Source files
------------

// File: rtl/audio_capture_recorder.sv
// Records one CODEC channel into a 16-bit RAM from address 0, draining the CODEC in every state.
// Optional rounding/saturation of the 24->16 bit conversion: define AUDIO_REC_ROUND_SAT_EN.
module audio_capture_recorder #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 52612,
  parameter int DECIM  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              channel_sel,
  input  logic              read_ready,
  input  logic [23:0]       readdata_left,
  input  logic [23:0]       readdata_right,
  output logic              read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DECIM - 1);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] decim_cnt;
  logic             last_write;
  logic             accept_p0;

`ifdef AUDIO_REC_ROUND_SAT_EN
  logic signed [8:0] sample_p0;
  logic [6:0]        unused_lsbs;

  // Round half up on bit 7; only the positive end can overflow.
  function automatic logic [15:0] round_sat(input logic [16:0] s);
    logic signed [16:0] sum;
    sum = $signed({s[16], s[16:1]}) + $signed({16'd0, s[0]});
    if (sum > 17'sd32767)
      return 16'h7FFF;
    else
      return sum[15:0];
  endfunction

  logic [16:0] sel_hi;
  assign sel_hi      = channel_sel ? readdata_right[23:7] : readdata_left[23:7];
  assign unused_lsbs = readdata_left[6:0] ^ readdata_right[6:0];
  assign sample_p0   = '0;
`else
  logic [7:0] unused_lsbs;

  function automatic logic [15:0] round_sat(input logic [15:0] s);
    return s;
  endfunction

  logic [15:0] sel_hi;
  assign sel_hi      = channel_sel ? readdata_right[23:8] : readdata_left[23:8];
  assign unused_lsbs = readdata_left[7:0] ^ readdata_right[7:0];
`endif

  // A write finishing at the last address ends the recording; no sample is taken on that edge.
  assign last_write = mem_we && (mem_addr == LAST_ADDR);
  assign accept_p0  = read && !stop && !last_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      read       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      decim_cnt  <= '0;
    end else begin
      read   <= read_ready & ~read;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop)
            state <= ARM;
        end
        ARM: begin
          mem_addr   <= '0;
          word_count <= '0;
          decim_cnt  <= '0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          // Write stage: the word presented this cycle is committed at this edge.
          if (mem_we) begin
            word_count <= word_count + ADDR_W'(1);
            if (mem_addr != LAST_ADDR)
              mem_addr <= mem_addr + ADDR_W'(1);
          end
          if (stop || last_write)
            state <= DONE;
          // Capture stage: latch the selected channel on the edge ending a read cycle.
          if (accept_p0) begin
            decim_cnt <= (decim_cnt == LAST_CNT) ? '0 : decim_cnt + CNT_W'(1);
            if (decim_cnt == '0) begin
              mem_we    <= 1'b1;
              mem_wdata <= round_sat(sel_hi);
            end
          end
        end
        DONE: begin
          if (start)
            state <= ARM;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == ARM) || (state == CAPTURE);
  assign done = (state == DONE);

endmodule
